pong_com_ai: RTL and testbench

- Autonomous opponent for the Pong game loop. Consumes the game controller's ball and com-paddle position outputs and drives the com paddle's button line, closing the loop on the consumer side of the position interface.
- Runs on the game tick clock. Emulates a human player: delayed reaction, a dead zone, and an occasional pseudo-random aiming mistake.

---
 rtl/pong_pkg.sv | 32 +++
 rtl/pong_com_ai_if.sv | 32 +++
 rtl/pong_com_ai_lfsr8.sv | 22 ++
 rtl/pong_com_ai.sv | 149 ++++++++++++++
 tb/tb_pong_com_ai.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Geometry and AI-state definitions shared by the Pong game controller and the
// computer-opponent logic.
package pong_pkg;

   localparam int H           = 120;
   localparam int W           = 160;
   localparam int BLOCK       = 4;
   localparam int PADDLE_SIZE = 32;

   localparam int PADDLE_CENTER  = H / 2 - PADDLE_SIZE / 2;
   localparam int PADDLE_MAX_TOP = H - 1 - PADDLE_SIZE;

   typedef enum logic [1:0] {
      AI_CENTER     = 2'd0,
      AI_TRACK      = 2'd1,
      AI_SERVE_HOLD = 2'd2
   } ai_state_t;

   // Keeps a requested paddle top inside the playfield.
   function automatic logic signed [8:0] clamp_top(input logic signed [8:0] t);
      logic signed [8:0] max_top;
      max_top = 9'(PADDLE_MAX_TOP);
      if (t < 9'sd0) begin
         return 9'sd0;
      end
      if (t > max_top) begin
         return max_top;
      end
      return t;
   endfunction

endpackage

// File: rtl/pong_com_ai_if.sv
// Position and button signals between the game controller and the com-paddle AI.
interface pong_com_ai_if;

   logic       enable;
   logic [7:0] ballX;
   logic [6:0] ballY;
   logic [6:0] comYPos;
   logic       com_btn;
   logic [1:0] ai_state;
   logic       miss_active;

   modport master (
      output enable,
      output ballX,
      output ballY,
      output comYPos,
      input  com_btn,
      input  ai_state,
      input  miss_active
   );

   modport slave (
      input  enable,
      input  ballX,
      input  ballY,
      input  comYPos,
      output com_btn,
      output ai_state,
      output miss_active
   );

endinterface

// File: rtl/pong_com_ai_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that only steps while enabled.
module lfsr8 (
   input  logic       GAME_CLK,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] seed,
   output logic [7:0] state
);

   logic feedback;

   assign feedback = state[7] ^ state[5] ^ state[4] ^ state[3];

   always_ff @(posedge GAME_CLK) begin
      if (reset) begin
         state <= seed;
      end else if (enable) begin
         state <= {state[6:0], feedback};
      end
   end

endmodule

// File: rtl/pong_com_ai.sv
// Computer opponent for Pong: follows a delayed copy of the ball height with a
// dead zone and occasional deliberate aiming errors, driving the com paddle button.
module pong_com_ai
   import pong_pkg::*;
#(
   parameter int         REACT_DELAY = 4,
   parameter int         DEAD_ZONE   = 2,
   parameter int         HOLD_CYCLES = 8,
   parameter int         MISS_OFFSET = 24,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic          GAME_CLK,
   input  logic          reset,
   pong_com_ai_if.slave  bus
);

   localparam logic [6:0]        Y_MID      = 7'(H / 2);
   localparam logic signed [8:0] CENTER_TOP = 9'(PADDLE_CENTER);
   localparam logic signed [8:0] TRACK_BIAS = 9'(BLOCK / 2 - PADDLE_SIZE / 2);
   localparam logic signed [8:0] MISS_ADJ   = 9'(MISS_OFFSET);
   localparam logic signed [8:0] DZ         = 9'(DEAD_ZONE);
   localparam logic [7:0]        HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

   logic [7:0]        lfsr;
   logic [6:0]        dly [REACT_DELAY];
   logic [6:0]        dly_y;
   logic [7:0]        prev_x;
   logic              prev_valid;
   ai_state_t         state;
   ai_state_t         state_next;
   logic [7:0]        hold_cnt;
   logic [7:0]        hold_next;
   logic              miss;
   logic              miss_next;
   logic              btn;
   logic              btn_next;
   logic              approach;
   logic              jump;
   logic signed [8:0] x_diff;
   logic signed [8:0] raw_target;
   logic signed [8:0] target;
   logic signed [8:0] err;

   lfsr8 u_lfsr (
      .GAME_CLK (GAME_CLK),
      .reset    (reset),
      .enable   (bus.enable),
      .seed     (LFSR_SEED),
      .state    (lfsr)
   );

   // Reaction delay: the AI only sees where the ball was REACT_DELAY ticks ago.
   always_ff @(posedge GAME_CLK) begin
      if (reset) begin
         for (int i = 0; i < REACT_DELAY; i++) begin
            dly[i] <= Y_MID;
         end
      end else if (bus.enable) begin
         dly[0] <= bus.ballY;
         for (int i = 1; i < REACT_DELAY; i++) begin
            dly[i] <= dly[i-1];
         end
      end
   end

   assign dly_y = dly[REACT_DELAY-1];

   // A step larger than one pixel means the ball was re-served, not moved.
   assign x_diff   = $signed({1'b0, bus.ballX}) - $signed({1'b0, prev_x});
   assign approach = prev_valid && (bus.ballX > prev_x);
   assign jump     = prev_valid && ((x_diff > 9'sd1) || (x_diff < -9'sd1));

   always_ff @(posedge GAME_CLK) begin
      if (reset) begin
         state      <= AI_CENTER;
         hold_cnt   <= 8'd0;
         miss       <= 1'b0;
         btn        <= 1'b1;
         prev_x     <= 8'd0;
         prev_valid <= 1'b0;
      end else if (bus.enable) begin
         state      <= state_next;
         hold_cnt   <= hold_next;
         miss       <= miss_next;
         btn        <= btn_next;
         prev_x     <= bus.ballX;
         prev_valid <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      hold_next  = hold_cnt;
      miss_next  = miss;
      if (jump) begin
         state_next = AI_SERVE_HOLD;
         hold_next  = HOLD_LOAD;
         miss_next  = 1'b0;
      end else begin
         case (state)
            AI_SERVE_HOLD: begin
               if (hold_cnt == 8'd0) begin
                  state_next = approach ? AI_TRACK : AI_CENTER;
               end else begin
                  hold_next = hold_cnt - 8'd1;
               end
            end
            AI_CENTER: begin
               if (approach) begin
                  state_next = AI_TRACK;
                  miss_next  = (lfsr[2:0] == 3'd0);
               end
            end
            AI_TRACK: begin
               if (!approach) begin
                  state_next = AI_CENTER;
                  miss_next  = 1'b0;
               end
            end
            default: begin
               state_next = AI_CENTER;
               miss_next  = 1'b0;
            end
         endcase
      end
   end

   // Inside the dead zone the button toggles every tick so the paddle stands still on average.
   always_comb begin
      raw_target = CENTER_TOP;
      if (state == AI_TRACK) begin
         raw_target = $signed({2'b00, dly_y}) + TRACK_BIAS + (miss ? MISS_ADJ : 9'sd0);
      end
      target = clamp_top(raw_target);
      err    = target - $signed({2'b00, bus.comYPos});
      if (err > DZ) begin
         btn_next = 1'b0;
      end else if (err < -DZ) begin
         btn_next = 1'b1;
      end else begin
         btn_next = ~btn;
      end
   end

   assign bus.com_btn     = btn;
   assign bus.ai_state    = state;
   assign bus.miss_active = miss;

endmodule

// File: tb/tb_pong_com_ai.sv
// Self-checking bench for pong_com_ai: directed scenarios plus a randomized ball
// walk, all compared every tick against a behavioural model of the opponent.
module tb_pong_com_ai;

   logic GAME_CLK;
   logic reset;
   bit   cmp_en;
   int   checks;
   int   errors;

   pong_com_ai_if bus ();

   pong_com_ai dut (
      .GAME_CLK (GAME_CLK),
      .reset    (reset),
      .bus      (bus)
   );

   initial begin
      GAME_CLK = 1'b0;
      forever #5 GAME_CLK = ~GAME_CLK;
   end

   // Behavioural model: mode 0 centre, 1 track, 2 serve hold.
   int         m_mode;
   bit         m_btn;
   bit         m_miss;
   logic [7:0] m_lfsr;
   int         m_hist[$];
   int         m_prev_x;
   bit         m_seen;
   int         m_hold;
   int         m_miss_count;

   task automatic modelReset();
      m_mode   = 0;
      m_btn    = 1'b1;
      m_miss   = 1'b0;
      m_lfsr   = 8'hA5;
      m_hist   = {};
      repeat (4) m_hist.push_back(60);
      m_prev_x = 0;
      m_seen   = 1'b0;
      m_hold   = 0;
   endtask

   task automatic modelStep(input int bx, input int by, input int cy);
      int  aim;
      int  diff;
      bit  toward;
      bit  served;
      aim = 44;
      if (m_mode == 1) begin
         aim = m_hist[0] + 2 - 16 + (m_miss ? 24 : 0);
      end
      if (aim < 0) aim = 0;
      if (aim > 87) aim = 87;
      diff = aim - cy;
      if (diff > 2) m_btn = 1'b0;
      else if (diff < -2) m_btn = 1'b1;
      else m_btn = !m_btn;

      toward = m_seen && (bx > m_prev_x);
      served = m_seen && ((bx - m_prev_x > 1) || (m_prev_x - bx > 1));
      if (served) begin
         m_mode = 2;
         m_hold = 7;
         m_miss = 1'b0;
      end else if (m_mode == 2) begin
         if (m_hold == 0) m_mode = toward ? 1 : 0;
         else m_hold = m_hold - 1;
      end else if (m_mode == 0) begin
         if (toward) begin
            m_mode = 1;
            m_miss = (m_lfsr % 8 == 0);
            if (m_miss) m_miss_count++;
         end
      end else if (!toward) begin
         m_mode = 0;
         m_miss = 1'b0;
      end

      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      void'(m_hist.pop_front());
      m_hist.push_back(by);
      m_prev_x = bx;
      m_seen   = 1'b1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Single compare process: advance the model with the values the DUT sampled, then compare.
   bit cap_rst;
   bit cap_en;
   int cap_bx;
   int cap_by;
   int cap_cy;

   always @(posedge GAME_CLK) begin
      cap_rst = reset;
      cap_en  = bus.enable;
      cap_bx  = int'(bus.ballX);
      cap_by  = int'(bus.ballY);
      cap_cy  = int'(bus.comYPos);
      if (cap_rst) modelReset();
      else if (cap_en) modelStep(cap_bx, cap_by, cap_cy);
      #1;
      if (cmp_en) begin
         checkOutput("model com_btn", int'(bus.com_btn), int'(m_btn));
         checkOutput("model ai_state", int'(bus.ai_state), m_mode);
         checkOutput("model miss_active", int'(bus.miss_active), int'(m_miss));
      end
   end

   task automatic applyStimulus(input bit r, input bit en, input int bx, input int by, input int cy);
      @(negedge GAME_CLK);
      reset       = r;
      bus.enable  = en;
      bus.ballX   = 8'(bx);
      bus.ballY   = 7'(by);
      bus.comYPos = 7'(cy);
      @(posedge GAME_CLK);
      #2;
   endtask

   int x;
   int y;
   int cy;
   int dir;

   initial begin
      checks       = 0;
      errors       = 0;
      m_miss_count = 0;
      reset        = 1'b1;
      bus.enable   = 1'b1;
      bus.ballX    = 8'd0;
      bus.ballY    = 7'd60;
      bus.comYPos  = 7'd40;
      cmp_en       = 1'b1;

      applyStimulus(1'b1, 1'b1, 0, 60, 40);
      applyStimulus(1'b1, 1'b1, 0, 60, 40);
      checkOutput("reset com_btn", int'(bus.com_btn), 1);
      checkOutput("reset ai_state", int'(bus.ai_state), 0);
      checkOutput("reset miss_active", int'(bus.miss_active), 0);

      // Approaching ball high in the field: paddle must keep moving down.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, 50 + i, 100, 40);
         if (i == 0) checkOutput("first tick ai_state", int'(bus.ai_state), 0);
         if (i == 1) checkOutput("track entry ai_state", int'(bus.ai_state), 1);
         if (i >= 5) checkOutput("track down com_btn", int'(bus.com_btn), 0);
      end

      // Within the dead zone the button alternates.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 60 + i, 100, 85);
         checkOutput("dither com_btn", int'(bus.com_btn), (i % 2 == 0) ? 1 : 0);
      end

      // Ball at the top edge: target clamps to 0.
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 64 + i, 2, 0);

      // Serve from the far side, then a second serve from 150 to 80.
      applyStimulus(1'b0, 1'b1, 150, 60, 60);
      checkOutput("serve ai_state", int'(bus.ai_state), 2);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 150, 60, 60);
      checkOutput("serve expiry ai_state", int'(bus.ai_state), 0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 1'b1, 80 + k, 60, 60);
         checkOutput("hold ai_state", int'(bus.ai_state), 2);
         checkOutput("hold com_btn", int'(bus.com_btn), 1);
      end
      applyStimulus(1'b0, 1'b1, 88, 60, 60);
      checkOutput("hold exit ai_state", int'(bus.ai_state), 1);

      // Freeze mid-track with wild inputs.
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 89 + i, 50, 30);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 5 + 30 * i, 120, 100);
      checkOutput("frozen ai_state", int'(bus.ai_state), 1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 93 + i, 50, 30);

      // Reset mid-track, then let the reloaded history steer the paddle.
      applyStimulus(1'b1, 1'b1, 97, 50, 30);
      checkOutput("midreset ai_state", int'(bus.ai_state), 0);
      checkOutput("midreset com_btn", int'(bus.com_btn), 1);
      checkOutput("midreset miss_active", int'(bus.miss_active), 0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 10 + i, 20, 45);

      // Randomized ball walk with serves, pauses, stalls and rare resets.
      x   = 40;
      y   = 60;
      cy  = 44;
      dir = 1;
      for (int t = 0; t < 4000; t++) begin
         if ($urandom_range(0, 11) == 0) dir = -dir;
         if ($urandom_range(0, 39) == 0) begin
            x = $urandom_range(0, 159);
         end else if ($urandom_range(0, 19) != 0) begin
            x = x + dir;
         end
         if (x > 159) begin x = 159; dir = -1; end
         if (x < 0) begin x = 0; dir = 1; end
         y = y + $urandom_range(0, 4) - 2;
         if (y < 0) y = 0;
         if (y > 127) y = 127;
         if ($urandom_range(0, 9) == 0) cy = $urandom_range(0, 127);
         else cy = cy + $urandom_range(0, 6) - 3;
         if (cy < 0) cy = 0;
         if (cy > 127) cy = 127;
         applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 15) != 0, x, y, cy);
      end

      if (m_miss_count == 0) $display("[TB] note: no aiming-error episode occurred");
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
